muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair.
- Executes MULTU/MULT/DIVU/DIV iteratively, one bit per cycle, and services MTHI/MTLO writes.
- Exposes HI/LO continuously so MFHI/MFLO can read them.
- Sits beside the ALU in EX. The decoder drives op/op_valid. The hazard unit stalls the pipeline while busy=1.

Parameters:
- WIDTH, 32, operand and HI/LO width (legal: 4..64).
- CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- op_valid  in  1  op request this cycle
- op  in  3  001 MULTU, 010 MULT, 011 DIVU, 100 DIV, 101 MTHI, 110 MTLO; 000/111 ignored
- src_a  in  WIDTH  rs value (multiplicand / dividend / MT* data)
- src_b  in  WIDTH  rt value (multiplier / divisor)
- flush  in  1  abort in-flight op, no writeback
- ready  out  1  unit idle, op accepted this cycle if op_valid=1
- busy  out  1  iterative op in flight; pipeline stall request
- done  out  1  one-cycle pulse; HI/LO updated by an iterative op
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE, hi=0, lo=0, done=0, counter=0, internal operand regs=0. ready=1 and busy=0 while in reset.
  - A reset asserted mid-operation discards the op and clears HI/LO.
- ready=(state==IDLE); busy=(state!=IDLE); both combinational from state.
- States: IDLE, CALC, FIX.
- IDLE, accept = op_valid & ready & ~flush:
  - MTHI: hi<=src_a at the edge. MTLO: lo<=src_a at the edge. Stay in IDLE, no done pulse.
  - MUL*/DIV*: latch operands, counter<=WIDTH, go to CALC.
  - Signed ops latch magnitudes plus a sign flag for the quotient/product and one for the remainder.
  - 000/111: no effect.
- CALC: one iteration per cycle, counter decrements; when counter reaches 1, the next edge goes to FIX.
  - Multiply: shift-add, producing a 2*WIDTH product.
  - Divide: restoring, one quotient bit per cycle, producing WIDTH-bit quotient and remainder.
- FIX: one edge applies sign correction (two's-complement negate per flag), writes {hi,lo}, sets done<=1 and returns to IDLE.
- done is high exactly one cycle, during which state=IDLE and hi/lo already hold the result.
- Latency: op accepted at edge E0 → done=1 and result visible after edge E0+WIDTH+1. Busy for WIDTH+1 cycles.
- Back-to-back: a new op may be accepted in the done cycle.
- Results:
  - MUL*: {hi,lo} = full 2*WIDTH product.
  - DIV*: lo=quotient, hi=remainder.
  - Signed divide truncates toward zero. Remainder sign = dividend sign.
- Divide by zero (either signedness): lo=all ones, hi=src_a unmodified, no sign correction. Still takes the full latency.
- Signed overflow (min_int / -1): lo=min_int, hi=0. This falls out of the magnitude path with no special case.
- flush:
  - In CALC or FIX: next edge state=IDLE, hi/lo unchanged, no done.
  - In IDLE: the coincident op (including MT*) is dropped.
  - flush wins over accept in every state.
- op_valid while busy: ignored, not queued. The hazard unit must hold the instruction.
- All outputs other than ready/busy are registered.

Test Plan:
- Reset then WIDTH=32 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after 33 cycles done=1 for one cycle; hi=0xFFFFFFFE, lo=0x00000001; busy=1 for exactly 33 cycles.
- MULT a=-3 (0xFFFFFFFD), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV a=-7, b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU a=100, b=0 → lo=0xFFFFFFFF, hi=100. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0x1234 then MTLO 0xABCD on consecutive cycles → hi=0x1234, lo=0xABCD one edge after each, done never pulses.
- Start DIVU 50/7, assert flush at CALC cycle 10, with prior hi=lo=0x5A → no done, hi/lo stay 0x5A, ready=1 next cycle. Assert rst_n=0 mid-CALC → hi=lo=0 immediately.
- WIDTH=8, CNT_W=4 instance: MULTU 200×3 → hi=0x02, lo=0x58 after 9 cycles. MULTU issued in the done cycle of a previous op is accepted (ready=1).

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO register pair.
// MULTU/MULT use shift-add, DIVU/DIV use restoring division; both take one
// bit per cycle over magnitudes, then a single FIX cycle applies signs and
// writes HI/LO. MTHI/MTLO write directly from IDLE.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MULT  = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  // r_opnd: multiplicand (mul) or divisor (div) magnitude
  logic [WIDTH-1:0] r_opnd;
  // r_rem/r_quo: upper/lower product halves (mul) or remainder/quotient (div)
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic             r_done;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;

  logic             w_accept;
  logic             w_signed;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH-1:0] w_div_diff;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  function automatic logic [WIDTH-1:0] f_fix_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] f_fix_2w(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  assign ready    = (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign hi       = r_hi;
  assign lo       = r_lo;

  assign w_accept = op_valid & ready & ~flush;
  assign w_signed = (op == OP_MULT) | (op == OP_DIV);
  assign w_sa     = w_signed & src_a[WIDTH-1];
  assign w_sb     = w_signed & src_b[WIDTH-1];
  assign w_mag_a  = f_fix_w(src_a, w_sa);
  assign w_mag_b  = f_fix_w(src_b, w_sb);

  // Shift-add step: add multiplicand when the current multiplier LSB is set.
  assign w_mul_sum   = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_opnd} : '0);
  // Restoring step: shift next dividend bit into the partial remainder.
  // The low WIDTH bits of the difference are exact whenever w_div_ge holds.
  assign w_div_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
  assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opnd;

  // Next partial result for one iteration of the selected algorithm.
  always_comb begin
    w_rem_nxt = r_rem;
    w_quo_nxt = r_quo;
    if (r_is_div) begin
      if (w_div_ge) begin
        w_rem_nxt = w_div_diff;
        w_quo_nxt = {r_quo[WIDTH-2:0], 1'b1};
      end else begin
        w_rem_nxt = w_div_shift[WIDTH-1:0];
        w_quo_nxt = {r_quo[WIDTH-2:0], 1'b0};
      end
    end else begin
      {w_rem_nxt, w_quo_nxt} = {w_mul_sum, r_quo[WIDTH-1:1]};
    end
  end

  // Control FSM plus HI/LO and iteration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_done   <= 1'b0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (op)
              OP_MTHI: r_hi <= src_a;
              OP_MTLO: r_lo <= src_a;
              OP_MULTU, OP_MULT: begin
                r_opnd   <= w_mag_a;
                r_quo    <= w_mag_b;
                r_rem    <= '0;
                r_is_div <= 1'b0;
                r_neg_q  <= w_sa ^ w_sb;
                r_neg_r  <= 1'b0;
                r_div0   <= 1'b0;
                r_cnt    <= CNT_W'(WIDTH);
                r_state  <= S_CALC;
              end
              OP_DIVU, OP_DIV: begin
                r_opnd   <= w_mag_b;
                r_quo    <= w_mag_a;
                r_rem    <= '0;
                r_is_div <= 1'b1;
                r_neg_q  <= w_sa ^ w_sb;
                r_neg_r  <= w_sa;
                r_div0   <= (src_b == '0);
                r_cnt    <= CNT_W'(WIDTH);
                r_state  <= S_CALC;
              end
              default: ;
            endcase
          end
        end
        S_CALC: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_state <= S_FIX;
            end
          end
        end
        S_FIX: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            if (r_is_div) begin
              // With a zero divisor the remainder path reproduces |src_a|,
              // and re-applying the dividend sign restores src_a exactly.
              r_lo <= r_div0 ? '1 : f_fix_w(r_quo, r_neg_q);
              r_hi <= f_fix_w(r_rem, r_neg_r);
            end else begin
              {r_hi, r_lo} <= f_fix_2w({r_rem, r_quo}, r_neg_q);
            end
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a 32-bit instance driven from a vector
// table plus hand-written flush/reset/back-to-back sequences, and an 8-bit
// instance for narrow-width and done-cycle issue checks.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        v32, fl32, ready32, busy32, done32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, hi32, lo32;

  logic        v8, fl8, ready8, busy8, done8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .op_valid(v32), .op(op32), .src_a(a32), .src_b(b32),
    .flush(fl32), .ready(ready32), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
  );

  muldiv_unit #(.WIDTH(8), .CNT_W(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .op_valid(v8), .op(op8), .src_a(a8), .src_b(b8),
    .flush(fl8), .ready(ready8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the unit idle; returns at the sample after acceptance.
  task automatic start32(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    v32 = 1'b1; op32 = o; a32 = a; b32 = b;
    @(negedge clk);
    v32 = 1'b0; op32 = 3'b000;
  endtask

  task automatic wait32(output int lat, output int bc);
    lat = 0; bc = 0;
    while (!done32 && lat < 200) begin
      if (busy32) bc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic start8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    v8 = 1'b1; op8 = o; a8 = a; b8 = b;
    @(negedge clk);
    v8 = 1'b0; op8 = 3'b000;
  endtask

  task automatic wait8(output int lat, output int bc);
    lat = 0; bc = 0;
    while (!done8 && lat < 200) begin
      if (busy8) bc++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int  lat, bc;
    bit  seen;

    vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{3'd2, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{3'd3, 32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF};
    vecs[4]  = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{3'd3, 32'd50,       32'd7,        32'd1,        32'd7};
    vecs[6]  = '{3'd4, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[7]  = '{3'd2, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8]  = '{3'd4, 32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF};
    vecs[9]  = '{3'd1, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[10] = '{3'd2, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB};
    vecs[11] = '{3'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};

    rst_n = 1'b0;
    v32 = 1'b0; op32 = 3'b000; a32 = '0; b32 = '0; fl32 = 1'b0;
    v8  = 1'b0; op8  = 3'b000; a8  = '0; b8  = '0; fl8  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", ready32, 1);
    chk("rst_busy",  busy32,  0);
    chk("rst_done",  done32,  0);
    chk("rst_hi",    hi32,    0);
    chk("rst_lo",    lo32,    0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven arithmetic vectors
    for (int i = 0; i < 12; i++) begin
      start32(vecs[i].op, vecs[i].a, vecs[i].b);
      wait32(lat, bc);
      chk($sformatf("v%0d_latency", i), lat, 33);
      chk($sformatf("v%0d_busy_cycles", i), bc, 33);
      chk($sformatf("v%0d_hi", i), hi32, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), lo32, vecs[i].lo);
      @(negedge clk);
      chk($sformatf("v%0d_done_one_cycle", i), done32, 0);
    end

    // MTHI then MTLO on consecutive cycles
    v32 = 1'b1; op32 = 3'b101; a32 = 32'h1234;
    @(negedge clk);
    chk("mthi_hi", hi32, 32'h1234);
    chk("mthi_done", done32, 0);
    op32 = 3'b110; a32 = 32'hABCD;
    @(negedge clk);
    v32 = 1'b0; op32 = 3'b000;
    chk("mtlo_lo", lo32, 32'hABCD);
    chk("mtlo_hi_kept", hi32, 32'h1234);
    chk("mtlo_done", done32, 0);

    // flush in IDLE drops an MTHI; op 111 is ignored
    v32 = 1'b1; op32 = 3'b101; a32 = 32'hFFFF; fl32 = 1'b1;
    @(negedge clk);
    fl32 = 1'b0; op32 = 3'b111; a32 = 32'h7777;
    @(negedge clk);
    v32 = 1'b0; op32 = 3'b000;
    chk("idle_flush_hi", hi32, 32'h1234);
    chk("op7_lo", lo32, 32'hABCD);
    chk("op7_busy", busy32, 0);

    // flush during CALC with hi=lo=0x5A
    v32 = 1'b1; op32 = 3'b101; a32 = 32'h5A;
    @(negedge clk);
    op32 = 3'b110;
    @(negedge clk);
    v32 = 1'b0; op32 = 3'b000;
    start32(3'd3, 32'd50, 32'd7);
    repeat (9) @(negedge clk);
    fl32 = 1'b1;
    @(negedge clk);
    fl32 = 1'b0;
    chk("calc_flush_ready", ready32, 1);
    chk("calc_flush_busy", busy32, 0);
    chk("calc_flush_hi", hi32, 32'h5A);
    chk("calc_flush_lo", lo32, 32'h5A);
    seen = 1'b0;
    repeat (40) begin
      if (done32) seen = 1'b1;
      @(negedge clk);
    end
    chk("calc_flush_no_done", seen, 0);

    // flush landing on the FIX cycle
    start32(3'd1, 32'd3, 32'd3);
    repeat (32) @(negedge clk);
    chk("fix_busy", busy32, 1);
    fl32 = 1'b1;
    @(negedge clk);
    fl32 = 1'b0;
    chk("fix_flush_done", done32, 0);
    chk("fix_flush_ready", ready32, 1);
    chk("fix_flush_hi", hi32, 32'h5A);
    chk("fix_flush_lo", lo32, 32'h5A);

    // op_valid while busy is ignored
    start32(3'd1, 32'd2, 32'd3);
    repeat (4) @(negedge clk);
    v32 = 1'b1; op32 = 3'b110; a32 = 32'hDEAD;
    @(negedge clk);
    v32 = 1'b0; op32 = 3'b000;
    wait32(lat, bc);
    chk("busy_ignore_done", done32, 1);
    chk("busy_ignore_hi", hi32, 32'd0);
    chk("busy_ignore_lo", lo32, 32'd6);
    @(negedge clk);

    // 8-bit instance: MULTU 200x3, then a MULTU issued in the done cycle
    start8(3'd1, 8'd200, 8'd3);
    wait8(lat, bc);
    chk("w8_latency", lat, 9);
    chk("w8_busy_cycles", bc, 9);
    chk("w8_hi", hi8, 8'h02);
    chk("w8_lo", lo8, 8'h58);
    chk("w8_ready_in_done", ready8, 1);
    v8 = 1'b1; op8 = 3'b001; a8 = 8'd15; b8 = 8'd17;
    @(negedge clk);
    v8 = 1'b0; op8 = 3'b000;
    chk("w8_b2b_accepted", busy8, 1);
    chk("w8_b2b_done_low", done8, 0);
    wait8(lat, bc);
    chk("w8_b2b_latency", lat, 9);
    chk("w8_b2b_hi", hi8, 8'h00);
    chk("w8_b2b_lo", lo8, 8'hFF);
    @(negedge clk);
    start8(3'd4, 8'h80, 8'hFF);
    wait8(lat, bc);
    chk("w8_ovf_hi", hi8, 8'h00);
    chk("w8_ovf_lo", lo8, 8'h80);
    @(negedge clk);
    start8(3'd4, 8'hF9, 8'h02);
    wait8(lat, bc);
    chk("w8_div_hi", hi8, 8'hFF);
    chk("w8_div_lo", lo8, 8'hFD);
    @(negedge clk);

    // Reset asserted mid-CALC clears HI/LO immediately
    start32(3'd1, 32'hFFFFFFFF, 32'd2);
    wait32(lat, bc);
    chk("pre_rst_hi", hi32, 32'h1);
    chk("pre_rst_lo", lo32, 32'hFFFFFFFE);
    @(negedge clk);
    start32(3'd1, 32'd9, 32'd9);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_hi", hi32, 0);
    chk("mid_rst_lo", lo32, 0);
    chk("mid_rst_ready", ready32, 1);
    chk("mid_rst_busy", busy32, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", ready32, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
